// File: rtl/ysyx_23060111_mem_arbiter.sv
// Two-master, one-slave memory arbiter (IFU = master 0, LSU = master 1).
// One transaction in flight. Round-robin grant on contention. A slave that
// stalls too long in REQ+RSP is answered with an error response.
module ysyx_23060111_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_rsp_err,

    output logic        s_req_valid,
    input  logic        s_req_ready,
    output logic [31:0] s_addr,
    output logic        s_wen,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_rsp_valid,
    output logic        s_rsp_ready,
    input  logic [31:0] s_rdata,
    input  logic        s_rsp_err,

    output logic        stale_rsp
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, RESP} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;

    logic             arb_gnt;
    logic             timed_out;

    // Winner of the IDLE arbitration: sole requester, else the one not served last.
    always_comb begin
        if (m0_req_valid && m1_req_valid) arb_gnt = ~last_gnt_q;
        else                              arb_gnt = m1_req_valid;
    end

    // >= rather than == so a REQ exit taken on the last allowed cycle still
    // leaves RSP bounded instead of letting the counter wrap.
    assign timed_out = (cnt_q >= CNT_LAST);

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        stale_d    = stale_q;

        // s_rsp_ready is high in IDLE/REQ; anything accepted there is orphaned.
        if ((state_q == IDLE || state_q == REQ) && s_rsp_valid) stale_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    gnt_d      = arb_gnt;
                    last_gnt_d = arb_gnt;
                    addr_d     = arb_gnt ? m1_addr  : m0_addr;
                    wen_d      = arb_gnt ? m1_wen   : m0_wen;
                    wdata_d    = arb_gnt ? m1_wdata : m0_wdata;
                    wstrb_d    = arb_gnt ? m1_wstrb : m0_wstrb;
                    cnt_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (s_req_ready) begin
                    state_d = RSP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (s_rsp_valid) begin
                    rdata_d = wen_q ? 32'h0 : s_rdata;
                    err_d   = s_rsp_err;
                    state_d = RESP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (gnt_q ? m1_rsp_ready : m0_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any slave access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
        end
    end

    // Handshake outputs decode from state; rst masks them all to 0.
    always_comb begin
        m0_req_ready = !rst && (state_q == IDLE) && !arb_gnt;
        m1_req_ready = !rst && (state_q == IDLE) &&  arb_gnt;
        s_req_valid  = !rst && (state_q == REQ);
        s_rsp_ready  = !rst && (state_q != RESP);
        m0_rsp_valid = !rst && (state_q == RESP) && !gnt_q;
        m1_rsp_valid = !rst && (state_q == RESP) &&  gnt_q;
    end

    // Response data only toward the granted master during RESP; 0 otherwise.
    always_comb begin
        m0_rdata   = ((state_q == RESP) && !gnt_q) ? rdata_q : 32'h0;
        m0_rsp_err = (state_q == RESP) && !gnt_q && err_q;
        m1_rdata   = ((state_q == RESP) &&  gnt_q) ? rdata_q : 32'h0;
        m1_rsp_err = (state_q == RESP) &&  gnt_q && err_q;
    end

    assign s_addr    = addr_q;
    assign s_wen     = wen_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign stale_rsp = stale_q;

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Directed bench for the two-master memory arbiter (TIMEOUT = 8).
// Inputs change 1 time unit after the rising edge; outputs are read at the
// falling edge.
module tb_ysyx_23060111_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        stale_rsp;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  exp2;
    logic [31:0] got32;
    logic [31:0] exp32;

    always #5 clk = ~clk;

    ysyx_23060111_mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m0_rdata(m0_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m1_rdata(m1_rdata), .m1_rsp_err(m1_rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rdata(s_rdata), .s_rsp_err(s_rsp_err),
        .stale_rsp(stale_rsp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req_valid = 0; m0_addr = 0; m0_wen = 0; m0_wdata = 0; m0_wstrb = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wstrb = 0; m1_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rdata = 0; s_rsp_err = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; m0_req_valid = 1; m1_req_valid = 1; s_rsp_valid = 1; s_req_ready = 1;
        m0_addr = 32'h1234_5678;
        step(); step();
        @(negedge clk);
        tests++; if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready} !== 6'b0)
            begin fails++; $display("FAIL reset_handshakes: got %b want 000000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}); end
        tests++; if ({s_addr, s_wdata, s_wstrb, s_wen} !== 69'b0)
            begin fails++; $display("FAIL reset_slave_fields: got addr %h wdata %h wstrb %b wen %b want zeros", s_addr, s_wdata, s_wstrb, s_wen); end
        tests++; if ({m0_rdata, m1_rdata, m0_rsp_err, m1_rsp_err, stale_rsp} !== 67'b0)
            begin fails++; $display("FAIL reset_master_rsp: got m0 %h m1 %h errs %b%b stale %b want zeros", m0_rdata, m1_rdata, m0_rsp_err, m1_rsp_err, stale_rsp); end
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        m0_req_valid = 1; m0_addr = 32'h8000_0000; m0_wen = 0; m0_wstrb = 4'hF;
        @(negedge clk);
        tests++; if ({m1_req_ready, m0_req_ready, s_req_valid} !== 3'b010)
            begin fails++; $display("FAIL rd_idle_ready: got %b want 010", {m1_req_ready, m0_req_ready, s_req_valid}); end
        step();                                   // E0: C0 = REQ
        m0_req_valid = 0; s_req_ready = 1;
        @(negedge clk);
        tests++; if ({s_req_valid, s_wen, s_addr, m0_req_ready} !== {1'b1, 1'b0, 32'h8000_0000, 1'b0})
            begin fails++; $display("FAIL rd_req: got v%b w%b a%h r%b want v1 w0 a80000000 r0", s_req_valid, s_wen, s_addr, m0_req_ready); end
        step();                                   // C1 = RSP
        s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if ({s_rsp_ready, s_req_valid, m0_rsp_valid} !== 3'b100)
            begin fails++; $display("FAIL rd_rsp_phase: got %b want 100", {s_rsp_ready, s_req_valid, m0_rsp_valid}); end
        step();                                   // C2 = RESP
        s_rsp_valid = 0; s_rdata = 0; m0_rsp_ready = 1;
        @(negedge clk);
        tests++; if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_err, s_rsp_ready} !== 4'b1000)
            begin fails++; $display("FAIL rd_resp_flags: got %b want 1000", {m0_rsp_valid, m1_rsp_valid, m0_rsp_err, s_rsp_ready}); end
        tests++; if (m0_rdata !== 32'hDEAD_BEEF)
            begin fails++; $display("FAIL rd_rdata: got %h want deadbeef", m0_rdata); end
        step();                                   // C3 = IDLE again
        m0_rsp_ready = 0; m0_req_valid = 1;
        @(negedge clk);
        tests++; if ({m0_req_ready, m0_rsp_valid, stale_rsp} !== 3'b100)
            begin fails++; $display("FAIL rd_turnaround: got %b want 100", {m0_req_ready, m0_rsp_valid, stale_rsp}); end
        m0_req_valid = 0;                         // withdraw before the edge
        step();
    endtask

    task automatic test_round_robin();
        rst = 1; step(); rst = 0;
        m0_req_valid = 1; m0_addr = 32'h0000_0100;
        m1_req_valid = 1; m1_addr = 32'h0000_0200;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            exp2 = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            tests++; if ({m1_req_ready, m0_req_ready} !== exp2)
                begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {m1_req_ready, m0_req_ready}, exp2); end
            step();
            s_req_ready = 1;
            @(negedge clk);
            exp32 = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            tests++; if (s_addr !== exp32)
                begin fails++; $display("FAIL rr_addr[%0d]: got %h want %h", i, s_addr, exp32); end
            step();
            s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'h1000 + i;
            step();
            s_rsp_valid = 0;
            @(negedge clk);
            got32 = (i % 2 == 0) ? m0_rdata : m1_rdata;
            tests++; if ({m1_rsp_valid, m0_rsp_valid} !== exp2 || got32 !== 32'h1000 + i)
                begin fails++; $display("FAIL rr_rsp[%0d]: got v%b d%h want v%b d%h", i, {m1_rsp_valid, m0_rsp_valid}, got32, exp2, 32'h1000 + i); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_lsu_write();
        m1_req_valid = 1; m1_addr = 32'h8000_1004; m1_wen = 1; m1_wdata = 32'h0000_00AB; m1_wstrb = 4'b0001;
        @(negedge clk);
        tests++; if ({m1_req_ready, m0_req_ready} !== 2'b10)
            begin fails++; $display("FAIL wr_grant: got %b want 10", {m1_req_ready, m0_req_ready}); end
        step();                                   // REQ
        m1_req_valid = 0; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'hFFFF_FFFF; m1_wstrb = 4'hF; m1_wen = 0;
        for (int k = 0; k < 6; k++) begin
            s_req_ready = (k == 5);
            @(negedge clk);
            tests++; if ({s_req_valid, s_wen, s_addr, s_wdata, s_wstrb} !== {1'b1, 1'b1, 32'h8000_1004, 32'h0000_00AB, 4'b0001})
                begin fails++; $display("FAIL wr_stable[%0d]: got v%b w%b a%h d%h s%b", k, s_req_valid, s_wen, s_addr, s_wdata, s_wstrb); end
            step();
        end
        s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'h1234_5678;
        step();                                   // RESP
        s_rsp_valid = 0; s_rdata = 0; m1_rsp_ready = 1;
        @(negedge clk);
        tests++; if ({m1_rsp_valid, m1_rsp_err, m0_rsp_valid, m1_rdata} !== {3'b100, 32'h0})
            begin fails++; $display("FAIL wr_resp: got v%b e%b m0v%b d%h want v1 e0 m0v0 d0", m1_rsp_valid, m1_rsp_err, m0_rsp_valid, m1_rdata); end
        step();
        clear_inputs();
    endtask

    task automatic test_slave_err();
        m0_req_valid = 1; m0_addr = 32'h8000_0040; m0_wen = 0;
        step();                                   // REQ
        m0_req_valid = 0; s_req_ready = 1;
        step();                                   // RSP
        s_req_ready = 0; s_rsp_valid = 1; s_rsp_err = 1; s_rdata = 32'hCAFE_F00D;
        step();                                   // RESP
        s_rsp_valid = 0; s_rsp_err = 0; s_rdata = 0; m0_rsp_ready = 1;
        @(negedge clk);
        tests++; if ({m0_rsp_valid, m0_rsp_err, m0_rdata} !== {2'b11, 32'hCAFE_F00D})
            begin fails++; $display("FAIL err_m0: got v%b e%b d%h want v1 e1 dcafef00d", m0_rsp_valid, m0_rsp_err, m0_rdata); end
        tests++; if ({m1_rsp_valid, m1_rsp_err, m1_rdata, stale_rsp} !== 35'b0)
            begin fails++; $display("FAIL err_m1_quiet: got v%b e%b d%h stale%b want zeros", m1_rsp_valid, m1_rsp_err, m1_rdata, stale_rsp); end
        step();
        clear_inputs();
    endtask

    task automatic test_timeout();
        m0_req_valid = 1; m0_addr = 32'h8000_0080; m0_wen = 0;
        step();                                   // E0: REQ entered
        m0_req_valid = 0; s_req_ready = 1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            tests++; if (m0_rsp_valid !== (k == 8))
                begin fails++; $display("FAIL to_valid[%0d]: got %b want %b", k, m0_rsp_valid, (k == 8)); end
            if (k < 8) begin
                step();
                s_req_ready = 0;
            end
        end
        tests++; if ({m0_rsp_err, m0_rdata, s_req_valid, m1_rsp_valid} !== {1'b1, 32'h0, 2'b00})
            begin fails++; $display("FAIL to_resp: got e%b d%h sv%b m1v%b want e1 d0 sv0 m1v0", m0_rsp_err, m0_rdata, s_req_valid, m1_rsp_valid); end
        m0_rsp_ready = 1;
        step();                                   // IDLE
        m0_rsp_ready = 0;
        @(negedge clk);
        tests++; if (stale_rsp !== 1'b0)
            begin fails++; $display("FAIL to_stale_before: got %b want 0", stale_rsp); end
        s_rsp_valid = 1; s_rdata = 32'hBAD0_BAD0;  // late slave answer
        step();
        s_rsp_valid = 0; s_rdata = 0;
        @(negedge clk);
        tests++; if ({stale_rsp, m0_rsp_valid} !== 2'b10)
            begin fails++; $display("FAIL to_stale_after: got %b want 10", {stale_rsp, m0_rsp_valid}); end
        step();
    endtask

    task automatic test_reset_mid();
        m1_req_valid = 1; m1_addr = 32'h8000_2000; m1_wen = 0;
        step();                                   // REQ
        m1_req_valid = 0; s_req_ready = 1;
        step();                                   // RSP
        s_req_ready = 0;
        rst = 1; m0_req_valid = 1; m0_addr = 32'h8000_3000; m0_wen = 0;
        @(negedge clk);
        tests++; if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready} !== 6'b0)
            begin fails++; $display("FAIL mid_rst_outputs: got %b want 000000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}); end
        step();                                   // back in IDLE
        rst = 0; s_rsp_valid = 1; s_rdata = 32'h5555_5555;
        @(negedge clk);
        tests++; if ({stale_rsp, m1_req_ready, m0_req_ready, s_req_valid} !== 4'b0010)
            begin fails++; $display("FAIL mid_idle: got %b want 0010", {stale_rsp, m1_req_ready, m0_req_ready, s_req_valid}); end
        step();                                   // REQ for the new request
        s_rsp_valid = 0; s_rdata = 0; m0_req_valid = 0; s_req_ready = 1;
        @(negedge clk);
        tests++; if ({stale_rsp, s_req_valid, s_addr} !== {2'b11, 32'h8000_3000})
            begin fails++; $display("FAIL mid_req: got stale%b v%b a%h want stale1 v1 a80003000", stale_rsp, s_req_valid, s_addr); end
        step();                                   // RSP
        s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'h600D_F00D;
        step();                                   // RESP
        s_rsp_valid = 0; s_rdata = 0; m0_rsp_ready = 1;
        @(negedge clk);
        tests++; if ({m0_rsp_valid, m0_rsp_err, m1_rsp_valid, m0_rdata} !== {3'b100, 32'h600D_F00D})
            begin fails++; $display("FAIL mid_resume: got v%b e%b m1v%b d%h want v1 e0 m1v0 d600df00d", m0_rsp_valid, m0_rsp_err, m1_rsp_valid, m0_rdata); end
        step();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lsu_write();
        test_slave_err();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
